// File: rtl/alu_seq.sv
// alu_seq: accumulator/E-register ALU with single-cycle ops plus
// multi-cycle MUL (shift-add) and ROR (one-bit-per-cycle rotate).
// Ports: clk, rst_n (async active-low); start/code/dr launch an op,
//        load_ac/ac_in load AC in IDLE; ac/e state, busy/done/zero status.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       code,
  input  logic [WIDTH-1:0] dr,
  input  logic             load_ac,
  input  logic [WIDTH-1:0] ac_in,
  output logic [WIDTH-1:0] ac,
  output logic             e,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic               is_mul, is_mul_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [2*WIDTH-1:0] prod, prod_nxt;
  logic [2*WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [WIDTH-1:0]   ac_nxt;
  logic               e_nxt, done_nxt;

  logic [WIDTH:0]     sum_add, sum_sub, sum_inc;
  logic [2*WIDTH-1:0] mul_acc;
  logic [CNT_W-1:0]   ror_n;

  assign sum_add = {1'b0, ac} + {1'b0, dr};
  assign sum_sub = {1'b0, ac} + {1'b0, ~dr} + {{WIDTH{1'b0}}, 1'b1};
  assign sum_inc = {1'b0, ac} + {{WIDTH{1'b0}}, 1'b1};
  // Partial product for the current step: multiplicand is pre-shifted left
  // once per step, so only the multiplier LSB is examined.
  assign mul_acc = prod + (mplier[0] ? mcand : '0);
  assign ror_n   = CNT_W'(32'(dr) % 32'(WIDTH));

  assign busy = (state == RUN);
  assign zero = (ac == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      is_mul <= 1'b0;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      ac     <= '0;
      e      <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      is_mul <= is_mul_nxt;
      cnt    <= cnt_nxt;
      prod   <= prod_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      ac     <= ac_nxt;
      e      <= e_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    is_mul_nxt = is_mul;
    cnt_nxt    = cnt;
    prod_nxt   = prod;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    ac_nxt     = ac;
    e_nxt      = e;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          done_nxt = 1'b1;
          case (code)
            4'd0:  ac_nxt = ac & dr;
            4'd1:  {e_nxt, ac_nxt} = sum_add;
            4'd2:  ac_nxt = dr;
            4'd3:  ac_nxt = ~ac;
            4'd4:  e_nxt = ~e;
            4'd5:  {ac_nxt, e_nxt} = {e, ac};
            4'd6:  {e_nxt, ac_nxt} = {ac, e};
            4'd7:  {e_nxt, ac_nxt} = sum_inc;
            4'd8:  ac_nxt = '0;
            4'd9:  e_nxt = 1'b0;
            4'd10: {e_nxt, ac_nxt} = sum_sub;
            4'd11: begin
              mcand_nxt  = {{WIDTH{1'b0}}, ac};
              mplier_nxt = dr;
              prod_nxt   = '0;
              cnt_nxt    = CNT_W'(WIDTH);
              is_mul_nxt = 1'b1;
              state_nxt  = RUN;
              done_nxt   = 1'b0;
            end
            4'd12: begin
              // A zero rotate amount completes immediately like a NOP.
              if (ror_n != '0) begin
                cnt_nxt    = ror_n;
                is_mul_nxt = 1'b0;
                state_nxt  = RUN;
                done_nxt   = 1'b0;
              end
            end
            default: ;
          endcase
        end else if (load_ac) begin
          ac_nxt = ac_in;
        end
      end
      RUN: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (is_mul) begin
          prod_nxt   = mul_acc;
          mcand_nxt  = mcand << 1;
          mplier_nxt = mplier >> 1;
          if (cnt == CNT_W'(1)) begin
            ac_nxt = mul_acc[WIDTH-1:0];
            e_nxt  = |mul_acc[2*WIDTH-1:WIDTH];
          end
        end else begin
          ac_nxt = {ac[0], ac[WIDTH-1:1]};
        end
        if (cnt == CNT_W'(1)) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  code;
  logic [15:0] dr;
  logic        load_ac;
  logic [15:0] ac_in;
  logic [15:0] ac;
  logic        e, busy, done, zero;

  int checks = 0;
  int failures = 0;
  int bc;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .code(code), .dr(dr),
    .load_ac(load_ac), .ac_in(ac_in), .ac(ac), .e(e), .busy(busy),
    .done(done), .zero(zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All helpers are entered and left at a falling edge.
  task automatic load(input logic [15:0] v);
    load_ac = 1'b1; ac_in = v;
    @(negedge clk);
    load_ac = 1'b0;
  endtask

  task automatic op(input logic [3:0] c, input logic [15:0] d);
    start = 1'b1; code = c; dr = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Launch a multi-cycle op and count busy cycles until done (bounded).
  task automatic run_multi(input logic [3:0] c, input logic [15:0] d, input string tag,
                           output int n);
    op(c, d);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      chk({tag, "_excl"}, {31'd0, done & busy}, 32'd0);
      if (done) break;
      if (busy) n++;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; code = 4'd0; dr = 16'd0;
    load_ac = 1'b0; ac_in = 16'd0;
    #3;
    chk("rst_ac", {16'd0, ac}, 32'd0);
    chk("rst_e", {31'd0, e}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD with carry out
    load(16'hFFFF);
    chk("load_ac", {16'd0, ac}, 32'hFFFF);
    chk("load_nodone", {31'd0, done}, 32'd0);
    op(4'd1, 16'h0001);
    chk("add_ac", {16'd0, ac}, 32'h0000);
    chk("add_e", {31'd0, e}, 32'd1);
    chk("add_zero", {31'd0, zero}, 32'd1);
    chk("add_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("add_done_1cyc", {31'd0, done}, 32'd0);

    // CLE, CIL, SUB
    load(16'h8000);
    op(4'd9, 16'h0000);
    chk("cle_e", {31'd0, e}, 32'd0);
    op(4'd6, 16'h0000);
    chk("cil_ac", {16'd0, ac}, 32'h0000);
    chk("cil_e", {31'd0, e}, 32'd1);
    load(16'h0003);
    op(4'd10, 16'h0005);
    chk("sub_ac", {16'd0, ac}, 32'hFFFE);
    chk("sub_e", {31'd0, e}, 32'd0);

    // back-to-back INC, INC
    start = 1'b1; code = 4'd7; dr = 16'd0;
    @(negedge clk);
    chk("inc1_ac", {16'd0, ac}, 32'hFFFF);
    chk("inc1_e", {31'd0, e}, 32'd0);
    chk("inc1_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("inc2_ac", {16'd0, ac}, 32'h0000);
    chk("inc2_e", {31'd0, e}, 32'd1);
    chk("inc2_done", {31'd0, done}, 32'd1);

    // AND, CMA, CIR, CME, LDA, NOP
    load(16'hF0F0);
    op(4'd0, 16'h0FF0);
    chk("and_ac", {16'd0, ac}, 32'h00F0);
    op(4'd3, 16'h0000);
    chk("cma_ac", {16'd0, ac}, 32'hFF0F);
    op(4'd5, 16'h0000);
    chk("cir_ac", {16'd0, ac}, 32'hFF87);
    chk("cir_e", {31'd0, e}, 32'd1);
    op(4'd4, 16'h0000);
    chk("cme_e", {31'd0, e}, 32'd0);
    op(4'd2, 16'h1234);
    chk("lda_ac", {16'd0, ac}, 32'h1234);
    op(4'd14, 16'hFFFF);
    chk("nop_ac", {16'd0, ac}, 32'h1234);
    chk("nop_done", {31'd0, done}, 32'd1);
    chk("nop_busy", {31'd0, busy}, 32'd0);

    // MUL 3*5
    load(16'h0003);
    run_multi(4'd11, 16'h0005, "mul1", bc);
    chk("mul1_busy_cycles", bc, 32'd16);
    chk("mul1_ac", {16'd0, ac}, 32'h000F);
    chk("mul1_e", {31'd0, e}, 32'd0);
    @(negedge clk);
    chk("mul1_done_1cyc", {31'd0, done}, 32'd0);

    // MUL overflow 0x100*0x100
    load(16'h0100);
    run_multi(4'd11, 16'h0100, "mul2", bc);
    chk("mul2_busy_cycles", bc, 32'd16);
    chk("mul2_ac", {16'd0, ac}, 32'h0000);
    chk("mul2_e", {31'd0, e}, 32'd1);

    // ROR by 4, then by 16 (== 0), then by 0x13 (== 3)
    load(16'h0001);
    run_multi(4'd12, 16'h0004, "ror4", bc);
    chk("ror4_busy_cycles", bc, 32'd4);
    chk("ror4_ac", {16'd0, ac}, 32'h1000);
    chk("ror4_e", {31'd0, e}, 32'd1);
    op(4'd12, 16'h0010);
    chk("ror0_ac", {16'd0, ac}, 32'h1000);
    chk("ror0_done", {31'd0, done}, 32'd1);
    chk("ror0_busy", {31'd0, busy}, 32'd0);
    run_multi(4'd12, 16'h0013, "ror3", bc);
    chk("ror3_busy_cycles", bc, 32'd3);
    chk("ror3_ac", {16'd0, ac}, 32'h0200);

    // start(CLA) and load_ac during MUL are ignored
    load(16'h0003);
    op(4'd11, 16'h0005);
    @(negedge clk); @(negedge clk);
    start = 1'b1; code = 4'd8; dr = 16'h0000; load_ac = 1'b1; ac_in = 16'hFFFF;
    @(negedge clk); @(negedge clk);
    start = 1'b0; load_ac = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("ign_done_seen", {31'd0, done}, 32'd1);
    chk("ign_ac", {16'd0, ac}, 32'h000F);
    chk("ign_e", {31'd0, e}, 32'd0);
    @(negedge clk);

    // reset mid-MUL
    load(16'h0003);
    op(4'd11, 16'h0005);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_ac", {16'd0, ac}, 32'd0);
    chk("mrst_e", {31'd0, e}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_nodone", {31'd0, done}, 32'd0);
    op(4'd1, 16'h0022);
    chk("mrst_add_ac", {16'd0, ac}, 32'h0022);
    chk("mrst_add_e", {31'd0, e}, 32'd0);
    chk("mrst_add_done", {31'd0, done}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
